// File: rtl/fn_sw_pkg.sv
// Shared operator encodings for the fn_sw datapath.
package fn_sw_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_XOR = 2'b01,
    OP_OR  = 2'b10,
    OP_ADD = 2'b11
  } op_e;

endpackage

// File: rtl/fn_sw_op.sv
// Combinational operator: AND/XOR/OR/ADD with carry-out for ADD only.
module fn_sw_op
  import fn_sw_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] y,
  output logic             co
);

  always_comb begin
    y  = '0;
    co = 1'b0;
    case (op_e'(sel))
      OP_AND: y = a & b;
      OP_XOR: y = a ^ b;
      OP_OR:  y = a | b;
      OP_ADD: {co, y} = {1'b0, a} + {1'b0, b};
      default: ;
    endcase
  end

endmodule

// File: rtl/fn_sw_pipe.sv
// Two-stage valid/ready operator pipeline (operand stage, result stage).
// Optional saturating output-transfer counter on port cnt: define FN_SW_PIPE_CNT_EN.
module fn_sw_pipe
  import fn_sw_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             co
`ifdef FN_SW_PIPE_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt
`endif
);

  if (WIDTH < 1 || WIDTH > 32 || CNT_W < 1) begin : g_bad_params
    $error("fn_sw_pipe: WIDTH must be 1..32 and CNT_W at least 1");
  end

  logic             s1_vld_q, s1_vld_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  op_e              sel_q, sel_d;
  logic             s2_vld_q, s2_vld_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             co_q, co_d;

  logic             s1_adv, s2_adv, in_acc;
  logic [WIDTH-1:0] op_y;
  logic             op_co;

  fn_sw_op #(.WIDTH(WIDTH)) u_op (
    .a   (a_q),
    .b   (b_q),
    .sel (sel_q),
    .y   (op_y),
    .co  (op_co)
  );

  // S2 frees up if empty or draining this cycle; S1 may then refill in the same cycle.
  assign s2_adv   = !s2_vld_q || out_ready;
  assign s1_adv   = s1_vld_q && s2_adv;
  assign in_ready = !s1_vld_q || s1_adv;
  assign in_acc   = in_valid && in_ready;

  always_comb begin
    s1_vld_d = s1_vld_q;
    a_d      = a_q;
    b_d      = b_q;
    sel_d    = sel_q;
    s2_vld_d = s2_vld_q;
    y_d      = y_q;
    co_d     = co_q;

    if (in_acc) begin
      s1_vld_d = 1'b1;
      a_d      = a;
      b_d      = b;
      sel_d    = op_e'(sel);
    end else if (s1_adv) begin
      s1_vld_d = 1'b0;
    end

    if (s2_adv) begin
      s2_vld_d = s1_vld_q;
    end
    if (s1_adv) begin
      y_d  = op_y;
      co_d = op_co;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= OP_AND;
      s2_vld_q <= 1'b0;
      y_q      <= '0;
      co_q     <= 1'b0;
    end else begin
      s1_vld_q <= s1_vld_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sel_q    <= sel_d;
      s2_vld_q <= s2_vld_d;
      y_q      <= y_d;
      co_q     <= co_d;
    end
  end

  assign out_valid = s2_vld_q;
  assign y         = y_q;
  assign co        = co_q;

`ifdef FN_SW_PIPE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && out_ready && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
`endif

endmodule
